des_cracker_top: RTL and testbench



---
 rtl/des_pkg.sv | 60 ++++++
 rtl/des_cracker_if.sv | 22 ++
 rtl/des_encrypt.sv | 59 +++++
 rtl/des_cracker_top.sv | 95 +++++++++
 tb/tb_des_cracker_top.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// DES constant tables and shared types for the DES key-search engine.
// Tables use FIPS 46 numbering: entry values are 1-based bit positions,
// bit 1 being the most significant bit of the source word.
// S-box constants pack 64 nibbles MSB-first, indexed by {row, column}.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEARCH    = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam int unsigned SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [255:0] SBOX_T [8] = '{
    256'he4d12fb83a6c5907_0f74e2d1a6cb9538_41e8d62bfc973a50_fc8249175b3ea06d,
    256'hf18e6b34972dc05a_3d47f28ec01a69b5_0e7ba4d158c6932f_d8a13f42b67c05e9,
    256'ha09e63f51dc7b428_d709346a285ecbf1_d6498f30b12c5ae7_1ad069874fe3b52c,
    256'h7de3069a1285bc4f_d8b56f03472c1ae9_a690cb7df13e5284_3f06a1d8945bc72e,
    256'h2c417ab6853fd0e9_eb2c47d150fa3986_421bad78f9c5630e_b8c71e2d6f09a453,
    256'hc1af92680d34e75b_af427c9561de0b38_9ef528c3704a1db6_432c95fabe17608d,
    256'h4b2ef08d3c975a61_d0b7491ae35c2f86_14bdc37eaf680592_6bd814a7950fe23c,
    256'hd2846fb1a93e50c7_1fd8a374c56b0e92_7b419ce206adf358_21e74a8dfc90356b};

endpackage

// File: rtl/des_cracker_if.sv
// Bus between the key-search engine and its controller.
//   Start      : controller -> engine, level sampled on each rising clk edge.
//   plaintext  : controller -> engine, known plaintext, stable during a search.
//   ciphertext : controller -> engine, target ciphertext, stable during a search.
//   count      : engine -> controller, registered key counter.
//   Key        : engine -> controller, parity-expanded key for count.
//   Found      : engine -> controller, registered match flag.
// Handshake: there is no valid/ready pair. Start acts as a request that is
// taken on any edge where the engine is IDLE, FOUND or EXHAUSTED and ignored
// while SEARCH; Found is the completion flag and stays high (with count/Key
// frozen) until the next accepted Start or reset.
interface des_cracker_if;
  logic        Start;
  logic [63:0] plaintext;
  logic [63:0] ciphertext;
  logic [55:0] count;
  logic [63:0] Key;
  logic        Found;

  modport master (output Start, plaintext, ciphertext, input count, Key, Found);
  modport slave  (input Start, plaintext, ciphertext, output count, Key, Found);
endinterface

// File: rtl/des_encrypt.sv
// Purely combinational single-block DES encryption (IP, 16 Feistel rounds
// with on-the-fly key schedule, FP). Parity bits of the key are dropped by PC-1.
//   i_plaintext  : 64-bit input block
//   i_key        : 64-bit key including parity bits
//   o_ciphertext : 64-bit encrypted block
module des_encrypt
  import des_pkg::*;
(
  input  logic [63:0] i_plaintext,
  input  logic [63:0] i_key,
  output logic [63:0] o_ciphertext
);

  function automatic logic [63:0] des_block(input logic [63:0] pt, input logic [63:0] key);
    logic [63:0] ip_x, pre, ct;
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk, e_x;
    logic [31:0] l, r, s, f, t;
    logic [5:0]  six;
    int unsigned idx;
    for (int k = 0; k < 64; k++) ip_x[63-k] = pt[64-IP_T[k]];
    for (int k = 0; k < 56; k++) cd[55-k] = key[64-PC1_T[k]];
    c = cd[55:28];
    d = cd[27:0];
    l = ip_x[63:32];
    r = ip_x[31:0];
    for (int rnd = 0; rnd < 16; rnd++) begin
      if (SHIFT_T[rnd] == 2) begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end else begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) sk[47-j] = cd[56-PC2_T[j]];
      for (int j = 0; j < 48; j++) e_x[47-j] = r[32-E_T[j]];
      e_x = e_x ^ sk;
      for (int b = 0; b < 8; b++) begin
        six = e_x[47-6*b -: 6];
        // Outer bits select the row, inner four the column.
        idx = {26'd0, six[5], six[0], six[4:1]};
        s[31-4*b -: 4] = SBOX_T[b][255-4*idx -: 4];
      end
      for (int j = 0; j < 32; j++) f[31-j] = s[32-P_T[j]];
      t = l ^ f;
      l = r;
      r = t;
    end
    // Halves are swapped after the last round.
    pre = {r, l};
    for (int k = 0; k < 64; k++) ct[63-k] = pre[64-FP_T[k]];
    return ct;
  endfunction

  assign o_ciphertext = des_block(i_plaintext, i_key);

endmodule

// File: rtl/des_cracker_top.sv
// Brute-force DES known-plaintext key search. After Start the 56-bit counter
// walks upward from zero, one key per clock; each count is parity-expanded to
// a DES key and used to encrypt the plaintext, and the search stops on a match
// with the target ciphertext or after MAX_COUNT keys.
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low
//   bus         : slave side of des_cracker_if (Start/plaintext/ciphertext in,
//                 count/Key/Found out)
//   o_dbg_state : current FSM state
module des_cracker_top
  import des_pkg::*;
#(
  parameter logic [56:0] MAX_COUNT = 57'd1 << 23
) (
  input  logic         clk,
  input  logic         reset,
  des_cracker_if.slave bus,
  output state_t       o_dbg_state
);

  localparam logic [55:0] LAST_COUNT = 56'(MAX_COUNT - 57'd1);

  state_t      r_state, w_state_nxt;
  logic [55:0] r_count, w_count_nxt;
  logic        r_found, w_found_nxt;
  logic [63:0] w_key, w_ct;
  logic        w_match, w_last;

  // Each 7-bit group of the count becomes the top of a key byte; the byte LSB
  // makes the byte's population count odd.
  function automatic logic [63:0] expand_key(input logic [55:0] c);
    logic [63:0] k;
    for (int i = 0; i < 8; i++) begin
      k[8*i+1 +: 7] = c[7*i +: 7];
      k[8*i]        = ~^c[7*i +: 7];
    end
    return k;
  endfunction

  assign w_key = expand_key(r_count);

  des_encrypt u_des (
    .i_plaintext (bus.plaintext),
    .i_key       (w_key),
    .o_ciphertext(w_ct)
  );

  assign w_match = (w_ct == bus.ciphertext);
  assign w_last  = (r_count == LAST_COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_found <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_found <= w_found_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:             if (bus.Start) w_state_nxt = SEARCH;
      SEARCH:           if (w_match) w_state_nxt = FOUND;
                        else if (w_last) w_state_nxt = EXHAUSTED;
      FOUND, EXHAUSTED: if (bus.Start) w_state_nxt = SEARCH;
      default:          w_state_nxt = IDLE;
    endcase
  end

  // Found is registered from the FOUND state, so it rises one edge after the
  // match is latched and drops on the same edge that accepts a restart.
  always_comb begin
    w_count_nxt = r_count;
    w_found_nxt = 1'b0;
    case (r_state)
      IDLE, EXHAUSTED: if (bus.Start) w_count_nxt = '0;
      SEARCH:          if (!w_match && !w_last) w_count_nxt = r_count + 56'd1;
      FOUND: begin
        if (bus.Start) w_count_nxt = '0;
        w_found_nxt = !bus.Start;
      end
      default:         w_count_nxt = '0;
    endcase
  end

  assign bus.count   = r_count;
  assign bus.Key     = w_key;
  assign bus.Found   = r_found;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_des_cracker_top.sv
module tb_des_cracker_top;
  import des_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  state_t dbg_a, dbg_b;
  des_cracker_if bus_a ();
  des_cracker_if bus_b ();

  des_cracker_top #(.MAX_COUNT(57'd1 << 23)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .o_dbg_state(dbg_a));
  des_cracker_top #(.MAX_COUNT(57'd16)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .o_dbg_state(dbg_b));

  int n_checks = 0;
  int n_errors = 0;
  logic [55:0] exp_q[$];

  typedef struct {
    logic [63:0] pt;
    logic [63:0] ct;
    logic [55:0] n;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_des(input logic [63:0] pt, input logic [63:0] key);
    bit kb[1:64], pb[1:64], cd[1:56], lr[1:64], er[1:48], sb[1:32], pre[1:64];
    bit l[1:32], r[1:32], nr[1:32];
    bit ks[16][1:48];
    bit t0, t1;
    int row, col;
    logic [3:0] v;
    logic [63:0] res;
    for (int i = 1; i <= 64; i++) begin kb[i] = key[64-i]; pb[i] = pt[64-i]; end
    for (int i = 1; i <= 56; i++) cd[i] = kb[PC1_T[i-1]];
    for (int rnd = 0; rnd < 16; rnd++) begin
      for (int s = 0; s < int'(SHIFT_T[rnd]); s++) begin
        t0 = cd[1];
        t1 = cd[29];
        for (int i = 1; i < 28; i++) begin cd[i] = cd[i+1]; cd[i+28] = cd[i+29]; end
        cd[28] = t0;
        cd[56] = t1;
      end
      for (int j = 1; j <= 48; j++) ks[rnd][j] = cd[PC2_T[j-1]];
    end
    for (int i = 1; i <= 64; i++) lr[i] = pb[IP_T[i-1]];
    for (int i = 1; i <= 32; i++) begin l[i] = lr[i]; r[i] = lr[i+32]; end
    for (int rnd = 0; rnd < 16; rnd++) begin
      for (int j = 1; j <= 48; j++) er[j] = r[E_T[j-1]] ^ ks[rnd][j];
      for (int b = 0; b < 8; b++) begin
        row = 2 * int'(er[6*b+1]) + int'(er[6*b+6]);
        col = 8 * int'(er[6*b+2]) + 4 * int'(er[6*b+3]) + 2 * int'(er[6*b+4]) + int'(er[6*b+5]);
        v = 4'(SBOX_T[b] >> (252 - 4 * (16 * row + col)));
        for (int q = 0; q < 4; q++) sb[4*b+1+q] = v[3-q];
      end
      for (int j = 1; j <= 32; j++) nr[j] = l[j] ^ sb[P_T[j-1]];
      l = r;
      r = nr;
    end
    for (int i = 1; i <= 32; i++) begin pre[i] = r[i]; pre[i+32] = l[i]; end
    for (int i = 1; i <= 64; i++) res[64-i] = pre[FP_T[i-1]];
    return res;
  endfunction

  function automatic logic [63:0] exp_key(input logic [55:0] c);
    logic [63:0] k;
    logic [6:0] g;
    k = '0;
    for (int b = 7; b >= 0; b--) begin
      g = c[7*b +: 7];
      k = {k[55:0], g, ($countones(g) % 2 == 0)};
    end
    return k;
  endfunction

  function automatic int odd_bytes(input logic [63:0] k);
    int n;
    logic [7:0] by;
    n = 0;
    for (int b = 0; b < 8; b++) begin
      by = k[8*b +: 8];
      if ($countones(by) % 2 == 1) n++;
    end
    return n;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic pulse_a();
    bus_a.Start = 1'b1;
    tick();
    bus_a.Start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int edges;
    logic got;
    logic [55:0] exp_n;
    bus_a.plaintext  = v.pt;
    bus_a.ciphertext = v.ct;
    exp_q.push_back(v.n);
    pulse_a();
    check({tag, "_count_at_start"}, 64'(bus_a.count), 64'd0);
    check({tag, "_found_at_start"}, 64'(bus_a.Found), 64'd0);
    edges = 0;
    got = 1'b0;
    while (!got && edges < int'(v.n) + 20) begin
      tick();
      edges++;
      got = bus_a.Found;
    end
    check({tag, "_found"}, 64'(got), 64'd1);
    exp_n = exp_q.pop_front();
    if (got) begin
      check({tag, "_latency"}, 64'(edges), 64'(exp_n) + 64'd2);
      check({tag, "_count"}, 64'(bus_a.count), 64'(exp_n));
      check({tag, "_key"}, bus_a.Key, exp_key(exp_n));
      check({tag, "_ref_des"}, ref_des(v.pt, bus_a.Key), v.ct);
      check({tag, "_parity"}, 64'(odd_bytes(bus_a.Key)), 64'd8);
      repeat (3) tick();
      check({tag, "_hold_found"}, 64'(bus_a.Found), 64'd1);
      check({tag, "_hold_count"}, 64'(bus_a.count), 64'(exp_n));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic found_seen;
    logic [63:0] rpt;
    bus_a.Start = 1'b0; bus_a.plaintext = '0; bus_a.ciphertext = '0;
    bus_b.Start = 1'b0; bus_b.plaintext = '0; bus_b.ciphertext = '0;

    // Reference model against well-known answers.
    check("ref_kat_classic", ref_des(64'h0123456789abcdef, 64'h133457799bbcdff1), 64'h85e813540f0ab405);
    check("ref_kat_zero", ref_des(64'h0, 64'h0101010101010101), 64'h8ca64de9c1b123a7);

    // Reset state.
    repeat (3) tick();
    check("rst_count", 64'(bus_a.count), 64'd0);
    check("rst_found", 64'(bus_a.Found), 64'd0);
    check("rst_key", bus_a.Key, 64'h0101010101010101);
    check("rst_state", 64'(dbg_a), 64'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_count", 64'(bus_a.count), 64'd0);
      check("idle_found", 64'(bus_a.Found), 64'd0);
    end
    check("idle_state", 64'(dbg_a), 64'(IDLE));

    // Table of searches: fixed known-answer hits at count 0, then targets
    // made by the reference model at chosen counts.
    rpt = {$urandom, $urandom};
    vecs[0] = '{pt: 64'h5eb98cbc40c4b52f, ct: 64'hef3756c1a9f551fe, n: 56'd0};
    vecs[1] = '{pt: 64'h0, ct: 64'h8ca64de9c1b123a7, n: 56'd0};
    vecs[2].pt = rpt;
    vecs[2].n  = 56'($urandom_range(20, 200));
    vecs[2].ct = ref_des(rpt, exp_key(vecs[2].n));
    vecs[3].pt = 64'h5eb98cbc40c4b52f;
    vecs[3].n  = 56'($urandom_range(500, 1500));
    vecs[3].ct = ref_des(vecs[3].pt, exp_key(vecs[3].n));
    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Restart from FOUND: Found drops on the Start edge and the rerun lands
    // on the same count.
    run_vec(vecs[3], "rerun");

    // Exhaustion on the 16-key instance.
    bus_b.plaintext  = 64'h0;
    bus_b.ciphertext = 64'h0123456789abcdef;
    bus_b.Start = 1'b1;
    tick();
    bus_b.Start = 1'b0;
    check("exh_count_at_start", 64'(bus_b.count), 64'd0);
    found_seen = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (bus_b.Found) found_seen = 1'b1;
      if (i == 15) begin
        check("exh_count_15", 64'(bus_b.count), 64'd15);
        check("exh_state_15", 64'(dbg_b), 64'(SEARCH));
      end
      if (i == 16) check("exh_state_16", 64'(dbg_b), 64'(EXHAUSTED));
    end
    check("exh_no_found", 64'(found_seen), 64'd0);
    check("exh_count_stuck", 64'(bus_b.count), 64'd15);
    check("exh_state", 64'(dbg_b), 64'(EXHAUSTED));
    bus_b.Start = 1'b1;
    tick();
    bus_b.Start = 1'b0;
    check("exh_restart_count0", 64'(bus_b.count), 64'd0);
    tick();
    check("exh_restart_count1", 64'(bus_b.count), 64'd1);
    check("exh_restart_state", 64'(dbg_b), 64'(SEARCH));

    // Start ignored mid-search, then asynchronous abort.
    bus_a.plaintext  = 64'h5eb98cbc40c4b52f;
    bus_a.ciphertext = 64'hdeadbeefdeadbeef;
    pulse_a();
    repeat (300) tick();
    check("mid_count_300", 64'(bus_a.count), 64'd300);
    pulse_a();
    check("mid_start_ignored", 64'(bus_a.count), 64'd301);
    repeat (699) tick();
    check("mid_count_1000", 64'(bus_a.count), 64'd1000);
    check("mid_state", 64'(dbg_a), 64'(SEARCH));
    #2;
    reset = 1'b0;
    #1;
    check("abort_count", 64'(bus_a.count), 64'd0);
    check("abort_found", 64'(bus_a.Found), 64'd0);
    check("abort_key", bus_a.Key, 64'h0101010101010101);
    check("abort_state", 64'(dbg_a), 64'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    repeat (5) tick();
    check("post_abort_count", 64'(bus_a.count), 64'd0);
    check("post_abort_state", 64'(dbg_a), 64'(IDLE));

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
